// File: rtl/simd_adder_pipe.sv
// simd_adder_pipe
//   Two-stage SIMD adder with valid/ready handshaking on both sides.
//   Stage 1 captures the operand set and its controls; stage 2 registers the
//   per-lane results computed from the stage-1 registers only.
//
//   Ports
//     clk        rising-edge clock for all state
//     rst        synchronous active-high reset
//     in_valid   operand set present on form/vec/op/A-D
//     in_ready   block accepts an operand set this cycle
//     form       0: paired add (Y1 = A op C, Y2 = B op D)
//                1: three-operand widened add (Y1 = high half, Y2 = low half)
//     vec        lane size: 0 = 8b, 1 = 16b, 2 = 32b, 3 = full 2*WIDTH
//     op         00 wrap add, 01 wrap sub, 10 unsigned sat add, 11 signed sat add
//     A, B, C, D operands, WIDTH bits each (WIDTH a multiple of 32)
//     out_valid  Y1/Y2 hold a valid result
//     out_ready  consumer accepts the result this cycle
//     Y1, Y2     registered results
module simd_adder_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             form,
   input  logic [1:0]       vec,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2
);

   // Stage 1 registers
   logic             s1_valid_q;
   logic             s1_form_q;
   logic [1:0]       s1_vec_q;
   logic [1:0]       s1_op_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q, s1_d_q;

   // Stage 2 registers
   logic             out_valid_q;
   logic [WIDTH-1:0] y1_q, y2_q;
   logic [WIDTH-1:0] y1_d, y2_d;

   logic               en;
   logic [2*WIDTH-1:0] wide;
   logic [5:0]         lane_w;
   logic [63:0]        lane_res;

   // One lane of the paired (form=0) operation; L = l bits held in the low
   // bits of a 34-bit container so sums and sign handling never overflow.
   function automatic logic [31:0] lane_arith(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic [1:0]  o,
                                              input logic [5:0]  l);
      logic [33:0]        mask, xu, yu, sum, r;
      logic signed [33:0] xs, ys, ss, smax, smin;
      mask = (34'd1 << l) - 34'd1;
      xu   = {2'b00, x} & mask;
      yu   = {2'b00, y} & mask;
      sum  = xu + yu;
      xs   = $signed(xu);
      ys   = $signed(yu);
      if (xu[l - 6'd1]) xs = xs - $signed(mask + 34'd1);
      if (yu[l - 6'd1]) ys = ys - $signed(mask + 34'd1);
      ss   = xs + ys;
      smax = $signed(mask >> 1);
      smin = -smax - 34'sd1;
      case (o)
         2'b00:   r = sum;
         2'b01:   r = xu - yu;
         2'b10:   r = (sum > mask) ? mask : sum;
         default: r = (ss > smax) ? $unsigned(smax) :
                      (ss < smin) ? $unsigned(smin) : $unsigned(ss);
      endcase
      return 32'(r & mask);
   endfunction

   // Returns {Y1 lane, Y2 lane} for one lane of width l.
   function automatic logic [63:0] lane_calc(input logic        f,
                                             input logic [1:0]  o,
                                             input logic [5:0]  l,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c,
                                             input logic [31:0] d);
      logic [33:0] mask, s;
      mask = (34'd1 << l) - 34'd1;
      if (f) begin
         s = ({2'b00, a} & mask) + ({2'b00, b} & mask) + ({2'b00, c} & mask);
         return {32'((s >> l) & mask), 32'(s & mask)};
      end
      return {lane_arith(a, c, o, l), lane_arith(b, d, o, l)};
   endfunction

   function automatic logic [31:0] chunk(input logic [WIDTH-1:0] v,
                                         input int unsigned      off);
      logic [WIDTH-1:0] t;
      t = v >> off;
      return t[31:0];
   endfunction

   function automatic logic [WIDTH-1:0] place(input logic [31:0] r,
                                              input int unsigned off);
      logic [WIDTH-1:0] t;
      t       = '0;
      t[31:0] = r;
      return t << off;
   endfunction

   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign Y1        = y1_q;
   assign Y2        = y2_q;

   // Lane results: each lane is extracted into a 32-bit container, computed,
   // masked to its width and OR-ed back at its offset, so lanes never interact.
   always_comb begin
      y1_d     = '0;
      y2_d     = '0;
      wide     = '0;
      lane_w   = 6'd8 << s1_vec_q;
      lane_res = '0;
      if (s1_vec_q == 2'd3) begin
         wide = s1_op_q[0] ? ({s1_a_q, s1_b_q} - {s1_c_q, s1_d_q})
                           : ({s1_a_q, s1_b_q} + {s1_c_q, s1_d_q});
         y1_d = wide[2*WIDTH-1:WIDTH];
         y2_d = wide[WIDTH-1:0];
      end else begin
         for (int unsigned i = 0; i < WIDTH / 8; i++) begin
            if (i < ((WIDTH / 8) >> s1_vec_q)) begin
               lane_res = lane_calc(s1_form_q, s1_op_q, lane_w,
                                    chunk(s1_a_q, i << (3 + s1_vec_q)),
                                    chunk(s1_b_q, i << (3 + s1_vec_q)),
                                    chunk(s1_c_q, i << (3 + s1_vec_q)),
                                    chunk(s1_d_q, i << (3 + s1_vec_q)));
               y1_d = y1_d | place(lane_res[63:32], i << (3 + s1_vec_q));
               y2_d = y2_d | place(lane_res[31:0],  i << (3 + s1_vec_q));
            end
         end
      end
   end

   // Both stages advance together on en; a stalled output freezes the whole pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         y1_q        <= '0;
         y2_q        <= '0;
      end else if (en) begin
         s1_valid_q  <= in_valid;
         out_valid_q <= s1_valid_q;
         if (in_valid) begin
            s1_form_q <= form;
            s1_vec_q  <= vec;
            s1_op_q   <= op;
            s1_a_q    <= A;
            s1_b_q    <= B;
            s1_c_q    <= C;
            s1_d_q    <= D;
         end
         if (s1_valid_q) begin
            y1_q <= y1_d;
            y2_q <= y2_d;
         end
      end
   end

endmodule

// File: tb/tb_simd_adder_pipe.sv
// Self-checking bench for simd_adder_pipe (WIDTH = 32): directed vectors,
// stall, reset and randomized traffic against an integer reference model.
module tb_simd_adder_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        form;
   logic [1:0]  vec;
   logic [1:0]  op;
   logic [31:0] A, B, C, D;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Y1, Y2;

   int checks = 0;
   int errors = 0;
   int outs   = 0;
   logic [63:0] expq[$];

   simd_adder_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .form(form), .vec(vec), .op(op), .A(A), .B(B), .C(C), .D(D),
      .out_valid(out_valid), .out_ready(out_ready), .Y1(Y1), .Y2(Y2)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic on plain integers, lane width L bits.
   function automatic logic [31:0] m_arith(input longint x, input longint y,
                                           input logic [1:0] o, input longint L);
      longint m, half, r, sx, sy;
      m    = (longint'(1) << L) - 1;
      half = longint'(1) << (L - 1);
      case (o)
         2'd0: r = x + y;
         2'd1: r = x - y;
         2'd2: r = (x + y > m) ? m : x + y;
         default: begin
            sx = (x >= half) ? x - 2 * half : x;
            sy = (y >= half) ? y - 2 * half : y;
            r  = sx + sy;
            if (r > half - 1) r = half - 1;
            else if (r < -half) r = -half;
         end
      endcase
      return 32'(r & m);
   endfunction

   function automatic logic [63:0] model(input logic f, input logic [1:0] v, input logic [1:0] o,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
      logic [63:0] full;
      logic [31:0] y1, y2, r1, r2;
      longint L, m, xa, xb, xc, xd, s;
      if (v == 2'd3) begin
         full = o[0] ? ({a, b} - {c, d}) : ({a, b} + {c, d});
         return full;
      end
      L  = longint'(8 << v);
      m  = (longint'(1) << L) - 1;
      y1 = '0;
      y2 = '0;
      for (int k = 0; k < 32 / L; k++) begin
         xa = (longint'(a) >> (k * L)) & m;
         xb = (longint'(b) >> (k * L)) & m;
         xc = (longint'(c) >> (k * L)) & m;
         xd = (longint'(d) >> (k * L)) & m;
         if (f) begin
            s  = xa + xb + xc;
            r1 = 32'((s >> L) & m);
            r2 = 32'(s & m);
         end else begin
            r1 = m_arith(xa, xc, o, L);
            r2 = m_arith(xb, xd, o, L);
         end
         y1 = y1 | 32'(longint'(r1) << (k * L));
         y2 = y2 | 32'(longint'(r2) << (k * L));
      end
      return {y1, y2};
   endfunction

   // Scoreboard: record accepted operand sets, compare results in order.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst) begin
         expq.delete();
      end else begin
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
         if (out_valid && out_ready) begin
            outs++;
            if (expq.size() == 0) begin
               chk("unexpected_result", {63'd0, 1'b1}, 64'd0);
            end else begin
               e = expq.pop_front();
               chk("result", {Y1, Y2}, e);
            end
         end
         if (in_valid && in_ready) expq.push_back(model(form, vec, op, A, B, C, D));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic [1:0] v, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
      form = f; vec = v; op = o; A = a; B = b; C = c; D = d;
   endtask

   task automatic drive_rand();
      drive(1'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom);
   endtask

   // One isolated transaction with latency checks; returns the result.
   task automatic dir(input string tag, input logic f, input logic [1:0] v, input logic [1:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d,
                      output logic [31:0] y1, output logic [31:0] y2);
      step();
      drive(f, v, o, a, b, c, d);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_accept"}, {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
      step();
      @(negedge clk);
      chk({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
      y1 = Y1;
      y2 = Y2;
      chk({tag, "_model"}, {Y1, Y2}, model(f, v, o, a, b, c, d));
   endtask

   // Present a set and wait (bounded) for it to be accepted.
   task automatic send(input logic f, input logic [1:0] v, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
      int n;
      drive(f, v, o, a, b, c, d);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((expq.size() != 0 || out_valid) && n < 50) begin
         step();
         n++;
      end
      @(negedge clk);
      chk({tag, "_drained"}, 64'(expq.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] y1, y2, s1, s2;
      int          o0;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(1'b0, 2'd0, 2'd0, '0, '0, '0, '0);
      step(); step();
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_y", {Y1, Y2}, 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      dir("v29", 1'b0, 2'd0, 2'b10, 32'h00FF8001, 32'h0, 32'h01010101, 32'h0, y1, y2);
      chk("v29_y1", 64'(y1), 64'h01FF8102);
      dir("v30", 1'b0, 2'd0, 2'b11, 32'h7F801000, 32'h0, 32'h01FF0505, 32'h0, y1, y2);
      chk("v30_y1", 64'(y1), 64'h7F801505);
      dir("v31", 1'b0, 2'd2, 2'b01, 32'h0, 32'h5, 32'h1, 32'h3, y1, y2);
      chk("v31_y", {y1, y2}, {32'hFFFFFFFF, 32'h00000002});
      dir("v32a", 1'b1, 2'd1, 2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'h2, 32'h0, y1, y2);
      chk("v32a_y", {y1, y2}, {32'h00000002, 32'h00000000});
      dir("v32b", 1'b0, 2'd3, 2'b00, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1, y1, y2);
      chk("v32b_y", {y1, y2}, {32'h00000001, 32'h00000000});
      dir("lanes16", 1'b0, 2'd1, 2'b00, 32'h0001FFFF, 32'h80000000, 32'h00010001, 32'h80000000, y1, y2);
      chk("lanes16_y", {y1, y2}, {32'h00020000, 32'h00000000});
      dir("sub8", 1'b0, 2'd0, 2'b01, 32'h00010000, 32'h0, 32'h01010101, 32'h0, y1, y2);
      chk("sub8_y1", 64'(y1), 64'hFF00FFFF);
      dir("full_sub", 1'b1, 2'd3, 2'b11, 32'h1, 32'h0, 32'h0, 32'h1, y1, y2);
      chk("full_sub_y", {y1, y2}, {32'h00000000, 32'hFFFFFFFF});
      dir("wide8", 1'b1, 2'd0, 2'b00, 32'hFF00FF80, 32'hFF000080, 32'hFF000001, 32'h0, y1, y2);
      chk("wide8_y", {y1, y2}, {32'h02000001, 32'hFD00FF01});
      drain("dir");

      // Throughput: in_valid held, out_ready high -> accept every cycle.
      o0 = outs;
      step();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive_rand();
         @(negedge clk);
         chk("tput_ready", {63'd0, in_ready}, 64'd1);
         step();
      end
      in_valid = 1'b0;
      drain("tput");
      chk("tput_count", 64'(outs - o0), 64'd8);

      // Stall: out_ready low for 3 cycles once the first result appears.
      o0 = outs;
      step();
      out_ready = 1'b1;
      send(1'b0, 2'd0, 2'b10, $urandom, $urandom, $urandom, $urandom);
      drive_rand();
      in_valid = 1'b1;
      step();
      out_ready = 1'b0;
      drive_rand();
      @(negedge clk);
      s1 = Y1;
      s2 = Y2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_hold", {Y1, Y2}, {s1, s2});
         step();
      end
      out_ready = 1'b1;
      send(form, vec, op, A, B, C, D);
      send(1'b1, 2'd2, 2'b00, $urandom, $urandom, $urandom, $urandom);
      drain("stall");
      chk("stall_count", 64'(outs - o0), 64'd4);

      // Randomized traffic with random backpressure.
      step();
      for (int k = 0; k < 400; k++) begin
         drive_rand();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand");

      // Reset with two sets in flight.
      step();
      out_ready = 1'b0;
      drive_rand();
      in_valid = 1'b1;
      step();
      drive_rand();
      step();
      @(negedge clk);
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      rst = 1'b1;
      drive_rand();
      step();
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_y", {Y1, Y2}, 64'd0);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      o0 = outs;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("no_stale", {63'd0, out_valid}, 64'd0);
         step();
      end
      chk("no_stale_count", 64'(outs - o0), 64'd0);
      chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
